// File: rtl/rx_chain_ctrl_pkg.sv
// Shared definitions for the receive-chain sequencer: FSM states, carrier
// amplitude and the quarter-wave sine table used by the carrier NCO.
package rx_chain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } rx_state_t;

    // Peak carrier magnitude; the table below is round(31*sin(2*pi*i/64))
    localparam int CARRIER_AMP = 31;

    // First quadrant of the 64-point sine, entries 0..15 (entry 16 is CARRIER_AMP)
    localparam logic [4:0] QUARTER_WAVE [16] = '{
        5'd0,  5'd3,  5'd6,  5'd9,  5'd12, 5'd15, 5'd17, 5'd20,
        5'd22, 5'd24, 5'd26, 5'd27, 5'd29, 5'd30, 5'd30, 5'd31
    };

    // Full 64-point sine from the quarter table: bit 4 mirrors, bit 5 negates
    function automatic logic signed [5:0] carrier_lookup(input logic [5:0] k);
        logic [3:0] idx;
        logic [4:0] mag;
        idx = k[3:0];
        if (k[4]) begin
            mag = (idx == 4'd0) ? 5'(CARRIER_AMP) : QUARTER_WAVE[4'd0 - idx];
        end else begin
            mag = QUARTER_WAVE[idx];
        end
        return k[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

endpackage

// File: rtl/rx_chain_ctrl_nco.sv
// Carrier NCO for the receive chain: phase accumulator, quarter-wave lookup
// and a registered SIN/COS pair. The output pair is always the lookup of the
// current phase, and is forced to zero while the chain is not enabled.
module rx_carrier_nco
    import rx_chain_ctrl_pkg::*;
#(
    parameter int PHASE_W = 8
) (
    input  logic               CLK_2,
    input  logic               RST,
    input  logic               EN,
    input  logic               CLR,
    input  logic [PHASE_W-1:0] FREQ_WORD,
    output logic signed [5:0]  SIN_C,
    output logic signed [5:0]  COS_C
);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] freq;
    logic [PHASE_W-1:0] phase_d;
    logic [5:0]         k_d;
    logic signed [5:0]  sin_q;
    logic signed [5:0]  cos_q;

    // Next phase: cleared on a new run, advanced by the latched step while enabled
    always_comb begin
        phase_d = phase;
        if (CLR) begin
            phase_d = '0;
        end else if (EN) begin
            phase_d = phase + freq;
        end
        k_d = phase_d[PHASE_W-1 -: 6];
    end

    // Phase, step and table outputs are registered together so the carrier matches the phase held in the same cycle
    always_ff @(posedge CLK_2) begin
        if (RST) begin
            phase <= '0;
            freq  <= '0;
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            phase <= phase_d;
            if (CLR) begin
                freq <= FREQ_WORD;
            end
            sin_q <= carrier_lookup(k_d);
            cos_q <= carrier_lookup(k_d + 6'd16);
        end
    end

    assign SIN_C = EN ? sin_q : '0;
    assign COS_C = EN ? cos_q : '0;

endmodule

// File: rtl/rx_chain_ctrl.sv
// Receive-chain sequencer: enables the chain, drives its carrier, discards the
// pipeline fill, then captures one frame of I/Q samples into a single output
// register that is drained downstream over valid/ready.
module rx_chain_ctrl
    import rx_chain_ctrl_pkg::*;
#(
    parameter int PHASE_W   = 8,
    parameter int FRAME_LEN = 64,
    parameter int FLUSH_CYC = 8
) (
    input  logic               CLK_2,
    input  logic               RST,
    input  logic               START,
    input  logic               ABORT,
    input  logic [PHASE_W-1:0] FREQ_WORD,
    input  logic signed [5:0]  I_CWM,
    input  logic signed [5:0]  Q_CWM,
    output logic               RX_EN,
    output logic signed [5:0]  SIN_C,
    output logic signed [5:0]  COS_C,
    output logic signed [5:0]  OUT_I,
    output logic signed [5:0]  OUT_Q,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               FRAME_LAST,
    output logic               BUSY,
    output logic               OVERRUN
);

    localparam int FLUSH_W  = $clog2(FLUSH_CYC + 1);
    localparam int SAMPLE_W = $clog2(FRAME_LEN + 1);
    localparam logic [FLUSH_W-1:0]  FLUSH_LAST  = FLUSH_W'(FLUSH_CYC - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(FRAME_LEN - 1);

    rx_state_t           state;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic [SAMPLE_W-1:0] sample_cnt;
    logic                out_accept;
    logic                start_accept;

    // Handshake completion and the start condition that restarts the carrier
    always_comb begin
        out_accept   = OUT_VALID && OUT_READY;
        start_accept = (state == IDLE) && START && !ABORT;
    end

    rx_carrier_nco #(
        .PHASE_W (PHASE_W)
    ) u_nco (
        .CLK_2     (CLK_2),
        .RST       (RST),
        .EN        (RX_EN),
        .CLR       (start_accept),
        .FREQ_WORD (FREQ_WORD),
        .SIN_C     (SIN_C),
        .COS_C     (COS_C)
    );

    assign BUSY = (state != IDLE);

    // Sequencer, counters and the single-entry output register; ABORT wins over everything but reset and leaves OVERRUN alone
    always_ff @(posedge CLK_2) begin
        if (RST) begin
            state      <= IDLE;
            RX_EN      <= 1'b0;
            OUT_I      <= '0;
            OUT_Q      <= '0;
            OUT_VALID  <= 1'b0;
            FRAME_LAST <= 1'b0;
            OVERRUN    <= 1'b0;
            flush_cnt  <= '0;
            sample_cnt <= '0;
        end else if (ABORT) begin
            state      <= IDLE;
            RX_EN      <= 1'b0;
            OUT_VALID  <= 1'b0;
            FRAME_LAST <= 1'b0;
            flush_cnt  <= '0;
            sample_cnt <= '0;
        end else begin
            if (out_accept) begin
                OUT_VALID  <= 1'b0;
                FRAME_LAST <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (START) begin
                        state      <= FLUSH;
                        RX_EN      <= 1'b1;
                        flush_cnt  <= '0;
                        sample_cnt <= '0;
                        OVERRUN    <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= STREAM;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end
                STREAM: begin
                    sample_cnt <= sample_cnt + SAMPLE_W'(1);
                    if (!OUT_VALID || out_accept) begin
                        OUT_I      <= I_CWM;
                        OUT_Q      <= Q_CWM;
                        OUT_VALID  <= 1'b1;
                        FRAME_LAST <= (sample_cnt == SAMPLE_LAST);
                    end else begin
                        OVERRUN <= 1'b1;
                    end
                    if (sample_cnt == SAMPLE_LAST) begin
                        state <= DRAIN;
                        RX_EN <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!OUT_VALID || out_accept) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_chain_ctrl.sv
// Bench for rx_chain_ctrl: directed carrier/frame/back-pressure/abort/reset
// scenarios followed by randomized traffic, all checked every cycle against a
// transaction-level reference model with a trigonometric carrier reference.
module tb_rx_chain_ctrl;

    localparam int PHASE_W   = 8;
    localparam int FRAME_LEN = 64;
    localparam int FLUSH_CYC = 8;

    logic               CLK_2 = 1'b0;
    logic               RST;
    logic               START;
    logic               ABORT;
    logic [PHASE_W-1:0] FREQ_WORD;
    logic signed [5:0]  I_CWM;
    logic signed [5:0]  Q_CWM;
    logic               RX_EN;
    logic signed [5:0]  SIN_C;
    logic signed [5:0]  COS_C;
    logic signed [5:0]  OUT_I;
    logic signed [5:0]  OUT_Q;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic               FRAME_LAST;
    logic               BUSY;
    logic               OVERRUN;

    rx_chain_ctrl #(
        .PHASE_W   (PHASE_W),
        .FRAME_LEN (FRAME_LEN),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .CLK_2      (CLK_2),
        .RST        (RST),
        .START      (START),
        .ABORT      (ABORT),
        .FREQ_WORD  (FREQ_WORD),
        .I_CWM      (I_CWM),
        .Q_CWM      (Q_CWM),
        .RX_EN      (RX_EN),
        .SIN_C      (SIN_C),
        .COS_C      (COS_C),
        .OUT_I      (OUT_I),
        .OUT_Q      (OUT_Q),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .FRAME_LAST (FRAME_LAST),
        .BUSY       (BUSY),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK_2 = ~CLK_2;

    int tests_run;
    int tests_failed;

    // Reference model: run time since start, samples offered, one held sample
    bit m_busy, m_run, m_hold_valid, m_hold_last, m_ovr;
    int m_t, m_offered, m_hold_i, m_hold_q, m_phase, m_freq;

    // Downstream scoreboard of what the DUT actually handed over
    int accept_count, last_count, last_at_index;
    int accepted_i[$];
    int ramp;

    function automatic int sin_ref(input int k);
        real v;
        v = 31.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 64.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clear_score();
        accept_count  = 0;
        last_count    = 0;
        last_at_index = 0;
        accepted_i.delete();
    endtask

    task automatic model_step(input bit rst, input bit st, input bit ab, input bit rdy,
                              input int fw, input int iv, input int qv);
        bit acc;
        acc = m_hold_valid && rdy;
        if (rst) begin
            m_busy = 0; m_run = 0; m_hold_valid = 0; m_hold_last = 0; m_ovr = 0;
            m_t = 0; m_offered = 0; m_phase = 0; m_freq = 0;
        end else if (ab) begin
            m_busy = 0; m_run = 0; m_hold_valid = 0; m_hold_last = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_run = 1; m_t = 0; m_phase = 0; m_ovr = 0; m_offered = 0;
                m_freq = fw % (1 << PHASE_W);
            end
        end else begin
            if (m_run) m_phase = (m_phase + m_freq) % (1 << PHASE_W);
            if (acc) begin
                m_hold_valid = 0;
                m_hold_last  = 0;
            end
            if (m_run) begin
                if (m_t >= FLUSH_CYC) begin
                    m_offered++;
                    if (!m_hold_valid) begin
                        m_hold_valid = 1;
                        m_hold_i     = iv;
                        m_hold_q     = qv;
                        m_hold_last  = (m_offered == FRAME_LEN);
                    end else begin
                        m_ovr = 1;
                    end
                    if (m_offered == FRAME_LEN) m_run = 0;
                end
            end else if (!m_hold_valid) begin
                m_busy = 0;
            end
            m_t++;
        end
    endtask

    task automatic compare_all();
        int k;
        k = m_phase >> (PHASE_W - 6);
        checkOutput("rx_en", RX_EN, m_run);
        checkOutput("busy", BUSY, m_busy);
        checkOutput("out_valid", OUT_VALID, m_hold_valid);
        checkOutput("frame_last", FRAME_LAST, m_hold_valid && m_hold_last);
        checkOutput("overrun", OVERRUN, m_ovr);
        checkOutput("sin_c", SIN_C, m_run ? sin_ref(k % 64) : 0);
        checkOutput("cos_c", COS_C, m_run ? sin_ref((k + 16) % 64) : 0);
        if (m_hold_valid) begin
            checkOutput("out_i", OUT_I, m_hold_i);
            checkOutput("out_q", OUT_Q, m_hold_q);
        end
    endtask

    // One clock: drive inputs, log the handshake, clock, advance model, compare
    task automatic applyStimulus(input bit rst, input bit st, input bit ab, input bit rdy, input int fw);
        RST       = rst;
        START     = st;
        ABORT     = ab;
        OUT_READY = rdy;
        FREQ_WORD = PHASE_W'(fw);
        I_CWM     = 6'(ramp);
        Q_CWM     = 6'($urandom);
        ramp++;
        if (OUT_VALID && OUT_READY) begin
            accept_count++;
            accepted_i.push_back(int'(OUT_I));
            if (FRAME_LAST) begin
                last_count++;
                last_at_index = accept_count;
            end
        end
        @(posedge CLK_2);
        model_step(rst, st, ab, rdy, fw, int'(I_CWM), int'(Q_CWM));
        #1;
        compare_all();
    endtask

    initial begin
        int sin_exp[4];
        int cos_exp[4];
        int fine[65];
        int busy_fall;
        int order_err;
        int held;
        bit rdy;

        sin_exp = '{0, 31, 0, -31};
        cos_exp = '{31, 0, -31, 0};
        tests_run = 0; tests_failed = 0; ramp = 0;
        m_busy = 0; m_run = 0; m_hold_valid = 0; m_hold_last = 0; m_ovr = 0;
        m_t = 0; m_offered = 0; m_hold_i = 0; m_hold_q = 0; m_phase = 0; m_freq = 0;
        RST = 1; START = 0; ABORT = 0; OUT_READY = 0; FREQ_WORD = '0; I_CWM = '0; Q_CWM = '0;
        clear_score();

        // Reset state
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_rx_en", RX_EN, 0);
        checkOutput("reset_sin", SIN_C, 0);
        checkOutput("reset_cos", COS_C, 0);
        checkOutput("reset_valid", OUT_VALID, 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Coarse carrier and a full frame without back-pressure
        clear_score();
        applyStimulus(0, 1, 0, 1, 64);
        checkOutput("start_busy", BUSY, 1);
        checkOutput("coarse_sin_first", SIN_C, 0);
        checkOutput("coarse_cos_first", COS_C, 31);
        busy_fall = 0;
        for (int c = 1; c < 200 && busy_fall == 0; c++) begin
            applyStimulus(0, 0, 0, 1, 0);
            if (c < 8) begin
                checkOutput("coarse_sin_seq", SIN_C, sin_exp[c % 4]);
                checkOutput("coarse_cos_seq", COS_C, cos_exp[c % 4]);
            end
            if (!BUSY) busy_fall = c + 1;
        end
        checkOutput("frame_busy_fall", busy_fall, FLUSH_CYC + FRAME_LEN + 2);
        checkOutput("frame_accepts", accept_count, FRAME_LEN);
        checkOutput("frame_last_count", last_count, 1);
        checkOutput("frame_last_pos", last_at_index, FRAME_LEN);
        checkOutput("frame_overrun", OVERRUN, 0);
        order_err = 0;
        for (int i = 1; i < accepted_i.size(); i++) begin
            if (((accepted_i[i] - accepted_i[i-1]) & 63) != 1) order_err++;
        end
        checkOutput("frame_order_errors", order_err, 0);

        // Fine carrier: one table step per cycle
        applyStimulus(0, 1, 0, 1, 4);
        fine[0] = SIN_C;
        for (int c = 1; c <= 64; c++) begin
            applyStimulus(0, 0, 0, 1, 0);
            fine[c] = SIN_C;
        end
        checkOutput("fine_step0", fine[0], 0);
        checkOutput("fine_step1", fine[1], 3);
        checkOutput("fine_step2", fine[2], 6);
        checkOutput("fine_step16", fine[16], 31);
        checkOutput("fine_step32", fine[32], 0);
        checkOutput("fine_step48", fine[48], -31);
        checkOutput("fine_step64", fine[64], 0);
        busy_fall = 0;
        for (int c = 0; c < 50 && busy_fall == 0; c++) begin
            applyStimulus(0, 0, 0, 1, 0);
            if (!BUSY) busy_fall = 1;
        end
        checkOutput("fine_drained", busy_fall, 1);

        // Back-pressure: five cycles of OUT_READY low mid-frame
        clear_score();
        applyStimulus(0, 1, 0, 1, $urandom_range(1, 255));
        busy_fall = 0;
        for (int c = 1; c < 200 && busy_fall == 0; c++) begin
            rdy = !(c >= 30 && c < 35);
            held = int'(OUT_I);
            applyStimulus(0, 0, 0, rdy, 0);
            if (!rdy) begin
                checkOutput("bp_hold_stable", OUT_I, held);
                checkOutput("bp_hold_valid", OUT_VALID, 1);
            end
            if (!BUSY) busy_fall = c + 1;
        end
        checkOutput("bp_busy_fall", busy_fall, FLUSH_CYC + FRAME_LEN + 2);
        checkOutput("bp_accepts", accept_count, FRAME_LEN - 5);
        checkOutput("bp_overrun", OVERRUN, 1);
        checkOutput("bp_last_count", last_count, 1);

        // ABORT in STREAM with a held sample, START in the same cycle
        applyStimulus(0, 1, 0, 1, 32);
        for (int c = 0; c < 20; c++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort_pre_valid", OUT_VALID, 1);
        applyStimulus(0, 1, 1, 1, 32);
        checkOutput("abort_rx_en", RX_EN, 0);
        checkOutput("abort_valid", OUT_VALID, 0);
        checkOutput("abort_busy", BUSY, 0);
        checkOutput("abort_overrun_kept", OVERRUN, 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("abort_start_ignored", BUSY, 0);
        applyStimulus(0, 1, 0, 1, 16);
        checkOutput("restart_busy", BUSY, 1);
        checkOutput("restart_overrun_clear", OVERRUN, 0);

        // Reset held for three cycles mid-STREAM
        for (int c = 0; c < 20; c++) applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)), 0);
        repeat (3) applyStimulus(1, 0, 0, 1, 0);
        checkOutput("rst_mid_busy", BUSY, 0);
        checkOutput("rst_mid_rx_en", RX_EN, 0);
        checkOutput("rst_mid_out_i", OUT_I, 0);
        checkOutput("rst_mid_out_q", OUT_Q, 0);
        checkOutput("rst_mid_valid", OUT_VALID, 0);
        checkOutput("rst_mid_overrun", OVERRUN, 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 399) == 0),
                          ($urandom_range(0, 3) != 0), $urandom_range(0, 255));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
